// File: rtl/clk_div_prog.sv
// clk_div_prog: programmable clock divider with glitch-free divisor updates applied only at period wrap.
module clk_div_prog #(
    parameter int unsigned CNT_W     = 16,
    parameter int unsigned DIV_RESET = 4
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             en,
    input  logic [CNT_W-1:0] div_in,
    input  logic             div_wr,
    output logic             clk_out,
    output logic             tick,
    output logic             busy,
    output logic             err,
    output logic [CNT_W-1:0] div_cur
);
    localparam logic [CNT_W-1:0] DIV_RST = CNT_W'(DIV_RESET);
    logic [CNT_W-1:0] d_q, d_d, p_q, p_d, cnt_q, cnt_d, cnt_nxt, h;
    logic clk_out_q, clk_out_d, tick_q, tick_d, busy_q, busy_d, err_q, err_d;
    logic wrap, wr_ok, apply;
    always_comb begin
        h         = d_q - (d_q >> 1);
        wrap      = cnt_q == d_q - CNT_W'(1);
        cnt_nxt   = wrap ? '0 : cnt_q + CNT_W'(1);
        wr_ok     = div_wr && div_in >= CNT_W'(2);
        // busy_q is the pre-edge value, so a write landing on a wrap waits for the next one
        apply     = en && wrap && busy_q;
        cnt_d     = en ? cnt_nxt : cnt_q;
        clk_out_d = en ? (cnt_nxt < h) : clk_out_q;
        tick_d    = en && wrap;
        d_d       = apply ? p_q : d_q;
        p_d       = wr_ok ? div_in : p_q;
        busy_d    = wr_ok || (busy_q && !apply);
        err_d     = div_wr && !wr_ok;
    end
    always_ff @(posedge clk_in or posedge reset) begin
        if (reset) begin
            d_q       <= DIV_RST;
            p_q       <= DIV_RST;
            cnt_q     <= DIV_RST - CNT_W'(1);
            clk_out_q <= 1'b0;
            tick_q    <= 1'b0;
            busy_q    <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            d_q       <= d_d;
            p_q       <= p_d;
            cnt_q     <= cnt_d;
            clk_out_q <= clk_out_d;
            tick_q    <= tick_d;
            busy_q    <= busy_d;
            err_q     <= err_d;
        end
    end
    assign clk_out = clk_out_q;
    assign tick    = tick_q;
    assign busy    = busy_q;
    assign err     = err_q;
    assign div_cur = d_q;
endmodule

// File: doc/clk_div_prog.md
CLK_DIV_PROG -- requirements
Module: clk_div_prog

Interface
REQ-001 Parameter CNT_W, default 16: width of the divisor and of the period counter.
REQ-002 Parameter DIV_RESET, default 4: divisor loaded at reset (50 MHz to 12.5 MHz); legal range 2 .. 2^CNT_W-1.
REQ-003 clk_in  input  1  single clock for the block.
REQ-004 reset  input  1  asynchronous, active-high reset.
REQ-005 en  input  1  count enable; 0 freezes counter and clk_out.
REQ-006 div_in  input  CNT_W  requested divisor.
REQ-007 div_wr  input  1  one-cycle write strobe for div_in.
REQ-008 clk_out  output  1  registered divided clock.
REQ-009 tick  output  1  one-cycle pulse, coincident with each clk_out rising edge.
REQ-010 busy  output  1  a divisor write is pending.
REQ-011 err  output  1  one-cycle pulse flagging a rejected write.
REQ-012 div_cur  output  CNT_W  divisor currently in effect.

Function
REQ-013 Internal state SHALL be: active divisor D, pending divisor P, counter cnt in 0..D-1, and H = D - floor(D/2) (ceiling of D/2).
REQ-014 On each clk_in edge with en=1, cnt SHALL advance: cnt_next = 0 when cnt = D-1, otherwise cnt+1.
REQ-015 On the same edge, clk_out SHALL load (cnt_next < H), giving period D, H cycles high and floor(D/2) cycles low, for both odd and even D.
REQ-016 tick SHALL load (en=1 and cnt_next = 0); tick is 0 on every other edge.
REQ-017 A div_wr with div_in >= 2 SHALL load P from div_in and set busy to 1 on the following cycle.
REQ-018 A div_wr with div_in < 2 SHALL be ignored, leave P and busy unchanged, and pulse err for exactly one cycle.
REQ-019 A pending P SHALL be applied (D = P, busy = 0) only on an enabled edge where cnt = D-1, so the new period starts at cnt = 0 with no truncated or glitched phase.
REQ-020 A valid div_wr while busy = 1 SHALL overwrite P; the last write wins.
REQ-021 A div_wr on the same edge as a wrap SHALL NOT be applied at that wrap; it is applied at the next wrap.
REQ-022 With en = 0: cnt, clk_out and D SHALL hold, tick SHALL be 0, and div_wr SHALL still be accepted into P.
REQ-023 div_cur SHALL equal D at all times.
REQ-024 All arithmetic SHALL be unsigned CNT_W-bit; cnt never exceeds D-1, so no wrap-around hazard exists.

Reset
REQ-025 While reset = 1, asynchronously: D = DIV_RESET, cnt = DIV_RESET-1, P = DIV_RESET, clk_out = 0, tick = 0, busy = 0, err = 0.
REQ-026 Reset asserted mid-period or with a write pending SHALL discard P and restore the REQ-025 values immediately.
REQ-027 After reset release with en = 1, the first edge SHALL give cnt = 0, clk_out = 1, tick = 1.

Verification
REQ-028 Reset release, en = 1, default D = 4 -> clk_out 1,1,0,0 repeating from the first edge; tick on edges 1, 5, 9, ...; div_cur = 4.
REQ-029 div_wr with div_in = 5 mid-period -> busy = 1 until the next wrap; then clk_out is 3 high, 2 low; div_cur = 5; busy = 0.
REQ-030 div_wr 6, then div_wr 3 two cycles later, both before the wrap -> only 3 is applied (period 3, 2 high, 1 low); 6 is never seen.
REQ-031 div_wr with div_in = 1, then with div_in = 0 -> err pulses once per write; busy stays 0; D unchanged.
REQ-032 en = 0 for 3 cycles while clk_out = 1 -> clk_out held at 1 and no tick; that period is extended by exactly 3 cycles; the phase then resumes.
REQ-033 reset asserted with D = 7 and P = 9 pending -> clk_out = 0, busy = 0, div_cur = 4 at once; after release, period 4.
